// File: rtl/mem_stage_pkg.sv
// Shared encodings and lane-steering helpers for the MEM pipeline stage.
package mem_stage_pkg;

   localparam int WordW    = 32;
   localparam int RegAddrW = 5;

   localparam logic [3:0] MemOpNop = 4'd0;
   localparam logic [3:0] MemOpLb  = 4'd1;
   localparam logic [3:0] MemOpLh  = 4'd2;
   localparam logic [3:0] MemOpLw  = 4'd3;
   localparam logic [3:0] MemOpLbu = 4'd4;
   localparam logic [3:0] MemOpLhu = 4'd5;
   localparam logic [3:0] MemOpSb  = 4'd6;
   localparam logic [3:0] MemOpSh  = 4'd7;
   localparam logic [3:0] MemOpSw  = 4'd8;

   localparam logic [3:0] BeNone   = 4'b0000;
   localparam logic [3:0] BeByte   = 4'b0001;
   localparam logic [3:0] BeHalfLo = 4'b0011;
   localparam logic [3:0] BeHalfHi = 4'b1100;
   localparam logic [3:0] BeWord   = 4'b1111;

   localparam int unsigned TimeoutCntW = 8;

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   function automatic logic is_mem_op(input logic [3:0] op);
      return (op != MemOpNop) && (op <= MemOpSw);
   endfunction

   function automatic logic is_load(input logic [3:0] op);
      return (op >= MemOpLb) && (op <= MemOpLhu);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op >= MemOpSb) && (op <= MemOpSw);
   endfunction

   function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
      logic mis;
      case (op)
         MemOpLh, MemOpLhu, MemOpSh: mis = off[0];
         MemOpLw, MemOpSw:           mis = (off != 2'b00);
         default:                    mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic [3:0] byte_en(input logic [3:0] op, input logic [1:0] off);
      logic [3:0] be;
      case (op)
         MemOpLb, MemOpLbu, MemOpSb: be = BeByte << off;
         MemOpLh, MemOpLhu, MemOpSh: be = off[1] ? BeHalfHi : BeHalfLo;
         MemOpLw, MemOpSw:           be = BeWord;
         default:                    be = BeNone;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] d);
      logic [31:0] r;
      case (op)
         MemOpSb: r = {4{d[7:0]}};
         MemOpSh: r = {2{d[15:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] off,
                                            input logic [31:0] data);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = data[{off, 3'b000} +: 8];
      h = off[1] ? data[31:16] : data[15:0];
      case (op)
         MemOpLb:  r = {{24{b[7]}}, b};
         MemOpLbu: r = {24'b0, b};
         MemOpLh:  r = {{16{h[15]}}, h};
         MemOpLhu: r = {16'b0, h};
         default:  r = data;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_reg.sv
// MEM/WB pipeline register: reset > flush (bubble) > stall (hold) > bubble request > load.
module mem_reg
   import mem_stage_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                stall,
   input  logic                bubble,
   input  logic                in_en,
   input  logic [RegAddrW-1:0] in_dst_addr,
   input  logic                in_gpr_we_,
   input  logic [WordW-1:0]    in_out,
   output logic                mem_en,
   output logic [RegAddrW-1:0] mem_dst_addr,
   output logic                mem_gpr_we_,
   output logic [WordW-1:0]    mem_out
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_en       <= 1'b0;
         mem_dst_addr <= '0;
         mem_gpr_we_  <= 1'b1;
         mem_out      <= '0;
      end else if (flush || (!stall && bubble)) begin
         mem_en       <= 1'b0;
         mem_dst_addr <= '0;
         mem_gpr_we_  <= 1'b1;
         mem_out      <= '0;
      end else if (!stall) begin
         mem_en       <= in_en;
         mem_dst_addr <= in_dst_addr;
         mem_gpr_we_  <= in_gpr_we_;
         mem_out      <= in_out;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: req/ack data bus, lane steering, load extension and MEM/WB register.
// Define MEM_BUS_TIMEOUT_EN to abandon bus accesses that wait TIMEOUT_CYCLES without ack.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                flush,
   input  logic                ex_en,
   input  logic [3:0]          ex_mem_op,
   input  logic [WordW-1:0]    ex_mem_wr_data,
   input  logic [WordW-1:0]    ex_out,
   input  logic [RegAddrW-1:0] ex_dst_addr,
   input  logic                ex_gpr_we_,
   output logic                bus_req,
   output logic                bus_rw,
   output logic [WordW-1:0]    bus_addr,
   output logic [3:0]          bus_be,
   output logic [WordW-1:0]    bus_wr_data,
   input  logic [WordW-1:0]    bus_rd_data,
   input  logic                bus_ack,
   output logic [WordW-1:0]    mem_fwd_data,
   output logic                mem_busy,
   output logic                mem_misalign,
   output logic                mem_bus_err,
   output logic                mem_en,
   output logic [RegAddrW-1:0] mem_dst_addr,
   output logic                mem_gpr_we_,
   output logic [WordW-1:0]    mem_out
);

   state_e           state_q, state_d;
   logic [3:0]       lat_op_q;
   logic [WordW-1:0] lat_addr_q, lat_wr_data_q, rd_buf_q;
   logic             abort_q;

   logic [3:0]       cur_op;
   logic [WordW-1:0] cur_addr, cur_wr_data, load_data, fwd;
   logic             is_mis, start, misalign, timeout, req, busy, discard, bubble;

   assign is_mis   = ex_en && is_mem_op(ex_mem_op) && is_misaligned(ex_mem_op, ex_out[1:0]);
   assign start    = (state_q == StIdle) && ex_en && is_mem_op(ex_mem_op) && !is_mis && !flush;
   assign misalign = (state_q == StIdle) && is_mis && !flush;

   // After IDLE the access attributes come from the latched copy so a flushed EX/MEM
   // cannot disturb an access the bus has already accepted.
   assign cur_op      = (state_q == StIdle) ? ex_mem_op      : lat_op_q;
   assign cur_addr    = (state_q == StIdle) ? ex_out         : lat_addr_q;
   assign cur_wr_data = (state_q == StIdle) ? ex_mem_wr_data : lat_wr_data_q;
   assign load_data   = load_ext(cur_op, cur_addr[1:0], bus_rd_data);
   assign req         = start || ((state_q == StWait) && !timeout);

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      discard = 1'b0;
      fwd     = ex_out;
      case (state_q)
         StIdle: begin
            if (start) begin
               if (bus_ack) begin
                  if (is_load(cur_op)) fwd = load_data;
                  if (stall) state_d = StDone;
               end else begin
                  busy    = 1'b1;
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            if (timeout) begin
               discard = 1'b1;
               state_d = StIdle;
            end else if (bus_ack) begin
               if (abort_q || flush) begin
                  discard = 1'b1;
                  state_d = StIdle;
               end else begin
                  if (is_load(cur_op)) fwd = load_data;
                  state_d = stall ? StDone : StIdle;
               end
            end else begin
               busy = 1'b1;
            end
         end
         StDone: begin
            if (is_load(cur_op)) fwd = rd_buf_q;
            if (!stall || flush) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         lat_op_q      <= MemOpNop;
         lat_addr_q    <= '0;
         lat_wr_data_q <= '0;
         rd_buf_q      <= '0;
         abort_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle) begin
            lat_op_q      <= ex_mem_op;
            lat_addr_q    <= ex_out;
            lat_wr_data_q <= ex_mem_wr_data;
         end
         if ((state_d == StDone) && (state_q != StDone)) rd_buf_q <= load_data;
         abort_q <= (state_d == StWait) && (abort_q || ((state_q == StWait) && flush));
      end
   end

`ifdef MEM_BUS_TIMEOUT_EN
   localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > TimeoutCntW) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : TimeoutCntW;
   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (state_q != StWait) begin
         cnt_q <= '0;
      end else if (!bus_ack) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign timeout     = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT_CYCLES));
   assign mem_bus_err = timeout && !reset;
`else
   logic [31:0] unused_timeout_cfg;
   assign unused_timeout_cfg = TIMEOUT_CYCLES + TimeoutCntW;
   assign timeout            = 1'b0;
   assign mem_bus_err        = 1'b0;
`endif

   always_comb begin
      bus_req      = req;
      bus_rw       = is_store(cur_op);
      bus_addr     = {cur_addr[WordW-1:2], 2'b00};
      bus_be       = byte_en(cur_op, cur_addr[1:0]);
      bus_wr_data  = store_lanes(cur_op, cur_wr_data);
      mem_fwd_data = fwd;
      mem_busy     = busy;
      mem_misalign = misalign;
      if (reset) begin
         bus_req      = 1'b0;
         bus_rw       = 1'b0;
         bus_addr     = '0;
         bus_be       = BeNone;
         bus_wr_data  = '0;
         mem_fwd_data = '0;
         mem_busy     = 1'b0;
         mem_misalign = 1'b0;
      end
   end

   assign bubble = !ex_en || busy || misalign || discard;

   mem_reg u_mem_reg (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .stall        (stall),
      .bubble       (bubble),
      .in_en        (ex_en),
      .in_dst_addr  (ex_dst_addr),
      .in_gpr_we_   (ex_gpr_we_ | is_store(cur_op)),
      .in_out       (fwd),
      .mem_en       (mem_en),
      .mem_dst_addr (mem_dst_addr),
      .mem_gpr_we_  (mem_gpr_we_),
      .mem_out      (mem_out)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized accesses
// checked against a transaction-level model of lanes, extension and MEM/WB contents.
module tb_mem_stage;

   logic        clk, reset, stall, flush, ex_en, ex_gpr_we_, bus_ack;
   logic [3:0]  ex_mem_op;
   logic [31:0] ex_mem_wr_data, ex_out, bus_rd_data;
   logic [4:0]  ex_dst_addr;
   logic        bus_req, bus_rw, mem_busy, mem_misalign, mem_bus_err, mem_en, mem_gpr_we_;
   logic [31:0] bus_addr, bus_wr_data, mem_fwd_data, mem_out;
   logic [3:0]  bus_be;
   logic [4:0]  mem_dst_addr;

   int checks = 0, errors = 0, txn_seen = 0, txn_exp = 0, err_pulses = 0;

   // expected MEM/WB contents
   logic        m_en, m_we;
   logic [4:0]  m_dst;
   logic [31:0] m_out;

   mem_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .ex_en          (ex_en),
      .ex_mem_op      (ex_mem_op),
      .ex_mem_wr_data (ex_mem_wr_data),
      .ex_out         (ex_out),
      .ex_dst_addr    (ex_dst_addr),
      .ex_gpr_we_     (ex_gpr_we_),
      .bus_req        (bus_req),
      .bus_rw         (bus_rw),
      .bus_addr       (bus_addr),
      .bus_be         (bus_be),
      .bus_wr_data    (bus_wr_data),
      .bus_rd_data    (bus_rd_data),
      .bus_ack        (bus_ack),
      .mem_fwd_data   (mem_fwd_data),
      .mem_busy       (mem_busy),
      .mem_misalign   (mem_misalign),
      .mem_bus_err    (mem_bus_err),
      .mem_en         (mem_en),
      .mem_dst_addr   (mem_dst_addr),
      .mem_gpr_we_    (mem_gpr_we_),
      .mem_out        (mem_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (!reset && bus_req && bus_ack) txn_seen++;
   always @(negedge clk) if (mem_bus_err === 1'b1) err_pulses++;

   function automatic int size_of(input int op);
      case (op)
         1, 4, 6: return 1;
         2, 5, 7: return 2;
         3, 8:    return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit is_ld(input int op);
      return op >= 1 && op <= 5;
   endfunction

   function automatic bit is_st(input int op);
      return op >= 6 && op <= 8;
   endfunction

   function automatic bit misal(input int op, input logic [31:0] a);
      int sz;
      sz = size_of(op);
      return sz != 0 && (a % sz) != 0;
   endfunction

   function automatic logic [3:0] m_be(input int op, input logic [31:0] a);
      int be;
      be = ((1 << size_of(op)) - 1) << (a % 4);
      return be[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input int op, input logic [31:0] wd);
      case (size_of(op))
         1:       return {24'b0, wd[7:0]} * 32'h0101_0101;
         2:       return {16'b0, wd[15:0]} * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input int op, input logic [31:0] a, input logic [31:0] rd);
      longint v, mask;
      v    = longint'(rd >> (8 * (a % 4)));
      mask = (longint'(1) << (8 * size_of(op))) - 1;
      v    = v & mask;
      if ((op == 1 || op == 2) && v >= (mask + 1) / 2) v = v - (mask + 1);
      return v[31:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_wb(input string tag);
      chk({tag, "_en"},  {31'b0, mem_en},      {31'b0, m_en});
      chk({tag, "_dst"}, {27'b0, mem_dst_addr}, {27'b0, m_dst});
      chk({tag, "_we"},  {31'b0, mem_gpr_we_}, {31'b0, m_we});
      chk({tag, "_out"}, mem_out, m_out);
   endtask

   task automatic set_bubble();
      m_en = 1'b0; m_we = 1'b1; m_dst = 5'd0; m_out = 32'd0;
   endtask

   // Entered and left at posedge+1 (or later, before the next edge).
   task automatic access(input int op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int dly, input bit stall_ack,
                         input logic [4:0] dst, input logic we);
      logic [31:0] exp_fwd;
      bit          is_mem, mis;
      is_mem  = size_of(op) != 0;
      mis     = misal(op, addr);
      exp_fwd = is_ld(op) ? m_load(op, addr, rd) : addr;
      ex_en = 1'b1; ex_mem_op = 4'(op); ex_out = addr; ex_mem_wr_data = wd;
      ex_dst_addr = dst; ex_gpr_we_ = we; flush = 1'b0;
      stall       = stall_ack && dly == 0 && is_mem && !mis;
      bus_ack     = is_mem && !mis && dly == 0;
      bus_rd_data = (dly == 0) ? rd : $urandom;
      #1;
      if (!is_mem || mis) begin
         chk("idle_req", {31'b0, bus_req}, 32'd0);
         chk("misalign_flag", {31'b0, mem_misalign}, {31'b0, mis});
         chk("idle_busy", {31'b0, mem_busy}, 32'd0);
         chk("idle_fwd", mem_fwd_data, addr);
         @(posedge clk); #1;
         ex_en = 1'b0; bus_ack = 1'b0; stall = 1'b0;
         #1;
         if (mis) set_bubble();
         else begin
            m_en = 1'b1; m_dst = dst; m_we = we; m_out = addr;
         end
         check_wb("nonmem");
         chk("misalign_clear", {31'b0, mem_misalign}, 32'd0);
         return;
      end
      txn_exp++;
      for (int k = 0; k <= dly; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
            if (k == 1) set_bubble();
            bus_ack = (k == dly);
            stall   = stall_ack && (k == dly);
            if (k == dly) bus_rd_data = rd;
            #1;
            check_wb("wait_wb");
         end
         chk("req", {31'b0, bus_req}, 32'd1);
         chk("rw", {31'b0, bus_rw}, {31'b0, is_st(op)});
         chk("addr", bus_addr, addr & ~32'h3);
         chk("be", {28'b0, bus_be}, {28'b0, m_be(op, addr)});
         if (is_st(op)) chk("wr_data", bus_wr_data, m_wdata(op, wd));
         chk("busy", {31'b0, mem_busy}, {31'b0, k < dly});
         if (k == dly) chk("fwd", mem_fwd_data, exp_fwd);
      end
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_rd_data = $urandom;
      if (stall_ack) begin
         for (int j = 0; j < 2; j++) begin
            #1;
            chk("done_req", {31'b0, bus_req}, 32'd0);
            chk("done_busy", {31'b0, mem_busy}, 32'd0);
            chk("done_fwd", mem_fwd_data, exp_fwd);
            check_wb("done_hold");
            @(posedge clk); #1;
         end
         stall = 1'b0;
         #1;
         chk("done_rel_req", {31'b0, bus_req}, 32'd0);
         chk("done_rel_fwd", mem_fwd_data, exp_fwd);
         @(posedge clk); #1;
      end
      ex_en = 1'b0; stall = 1'b0;
      #1;
      m_en = 1'b1; m_dst = dst; m_we = is_st(op) ? 1'b1 : we; m_out = exp_fwd;
      check_wb("wb_load");
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; ex_en = 1'b0; ex_mem_op = 4'd0;
      ex_mem_wr_data = 32'd0; ex_out = 32'd0; ex_dst_addr = 5'd0; ex_gpr_we_ = 1'b1;
      bus_rd_data = 32'd0; bus_ack = 1'b0;
      set_bubble();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", {31'b0, bus_req}, 32'd0);
      chk("rst_busy", {31'b0, mem_busy}, 32'd0);
      chk("rst_misalign", {31'b0, mem_misalign}, 32'd0);
      chk("rst_bus_err", {31'b0, mem_bus_err}, 32'd0);
      check_wb("rst");
      reset = 1'b0;
      @(posedge clk); #1;
      check_wb("post_rst");

      // zero-wait word load
      access(3, 32'h100, 32'd0, 32'hDEAD_BEEF, 0, 1'b0, 5'd5, 1'b0);
      chk("tp_lw_out", mem_out, 32'hDEAD_BEEF);
      chk("tp_lw_we", {31'b0, mem_gpr_we_}, 32'd0);
      // byte loads with wait states, signed and unsigned
      access(1, 32'h103, 32'd0, 32'h8012_3456, 3, 1'b0, 5'd3, 1'b0);
      chk("tp_lb_out", mem_out, 32'hFFFF_FF80);
      access(4, 32'h103, 32'd0, 32'h8012_3456, 3, 1'b0, 5'd3, 1'b0);
      chk("tp_lbu_out", mem_out, 32'h0000_0080);
      // halfword store
      access(7, 32'h202, 32'h0000_ABCD, 32'd0, 1, 1'b0, 5'd4, 1'b0);
      chk("tp_sh_we", {31'b0, mem_gpr_we_}, 32'd1);
      // misaligned word load
      access(3, 32'h101, 32'd0, 32'd0, 0, 1'b0, 5'd1, 1'b0);
      // stall at ack parks the result in DONE
      access(3, 32'h180, 32'd0, 32'h1234_5678, 2, 1'b1, 5'd9, 1'b0);
      chk("tp_stall_out", mem_out, 32'h1234_5678);
      // plain ALU result passes through
      access(0, 32'hCAFE_0001, 32'd0, 32'd0, 0, 1'b0, 5'd12, 1'b0);

      // flush while waiting: access completes on the bus but is discarded
      ex_en = 1'b1; ex_mem_op = 4'd3; ex_out = 32'h300; ex_dst_addr = 5'd7; ex_gpr_we_ = 1'b0;
      stall = 1'b0; flush = 1'b0; bus_ack = 1'b0;
      #1;
      chk("fl_req0", {31'b0, bus_req}, 32'd1);
      @(posedge clk); #1;
      flush = 1'b1;
      #1;
      chk("fl_req1", {31'b0, bus_req}, 32'd1);
      chk("fl_busy1", {31'b0, mem_busy}, 32'd1);
      @(posedge clk); #1;
      flush = 1'b0;
      #1;
      set_bubble();
      chk("fl_req2", {31'b0, bus_req}, 32'd1);
      chk("fl_addr", bus_addr, 32'h300);
      chk("fl_busy2", {31'b0, mem_busy}, 32'd1);
      check_wb("fl_wb");
      @(posedge clk); #1;
      bus_ack = 1'b1; bus_rd_data = $urandom;
      #1;
      chk("fl_req3", {31'b0, bus_req}, 32'd1);
      chk("fl_busy3", {31'b0, mem_busy}, 32'd0);
      @(posedge clk); #1;
      bus_ack = 1'b0; ex_en = 1'b0;
      #1;
      txn_exp++;
      check_wb("fl_discard");
      chk("fl_req4", {31'b0, bus_req}, 32'd0);

      // randomized accesses
      for (int i = 0; i < 60; i++) begin
         int          op, sz;
         logic [31:0] a;
         op = $urandom_range(0, 8);
         a  = $urandom;
         sz = size_of(op);
         if (sz != 0 && $urandom_range(0, 2) != 0) a = a & ~32'(sz - 1);
         access(op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                5'($urandom), 1'($urandom));
      end

      // asynchronous reset in the middle of a wait
      ex_en = 1'b1; ex_mem_op = 4'd3; ex_out = 32'h400; ex_dst_addr = 5'd2; ex_gpr_we_ = 1'b0;
      bus_ack = 1'b0; stall = 1'b0; flush = 1'b0;
      #1;
      chk("ar_req0", {31'b0, bus_req}, 32'd1);
      @(posedge clk); #1;
      chk("ar_busy_wait", {31'b0, mem_busy}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      set_bubble();
      chk("ar_req", {31'b0, bus_req}, 32'd0);
      chk("ar_busy", {31'b0, mem_busy}, 32'd0);
      chk("ar_fwd", mem_fwd_data, 32'd0);
      check_wb("ar_wb");
      ex_en = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("ar_idle_req", {31'b0, bus_req}, 32'd0);
      @(posedge clk); #1;
      check_wb("ar_post");

      chk("txn_count", txn_seen, txn_exp);
      chk("bus_err_pulses", err_pulses, 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
